// File: rtl/serial_add_pkg.sv
// Shared constants and types for the bit-serial adder.
package serial_add_pkg;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 14;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must be able to hold the value w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Bit-counter width for the default operand width.
    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_add_cell.sv
// One-bit combinational full adder used by the serial datapath.
module full_add_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: one bit per clock, LSB first, WIDTH cycles per sum.
// Reports unsigned carry-out and signed overflow alongside the result.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] first_num,
    input  logic [WIDTH-1:0] second_num,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic             r_carry;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_cout;
    logic             w_load;
    logic             w_last;

    // Current bit pair plus running carry.
    full_add_cell u_cell (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_c),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_last = (r_state == RUN) && (r_cnt == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a new operation may be accepted from IDLE or DONE.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, accumulator and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_a   <= first_num;
            r_b   <= second_num;
            r_acc <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_c   <= w_cout;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Result registers update only on the final bit and hold otherwise.
    // Overflow compares the carry into the MSB with the carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_last) begin
            r_result <= {w_sum, r_acc[WIDTH-1:1]};
            r_carry  <= w_cout;
            r_ovf    <= r_c ^ w_cout;
        end
    end

    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_add;

    localparam int W = 14;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] first_num = '0;
    logic [W-1:0] second_num = '0;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         busy;
    logic         done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   busy_run = 0;
    exp_t q[$];

    serial_add #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_num  (first_num),
        .second_num (second_num),
        .result     (result),
        .carry      (carry),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", int'(result), int'(e.res));
                    chk("carry", int'(carry), int'(e.c));
                    chk("overflow", int'(overflow), int'(e.o));
                    chk("latency_cycle", cyc, e.cyc);
                    chk("busy_cycles", busy_run, W);
                    $display("txn done: result=0x%0h carry=%0d overflow=%0d cycle=%0d",
                             result, carry, overflow, cyc);
                end
            end
            busy_run = busy ? busy_run + 1 : 0;
        end else begin
            busy_run = 0;
        end
    end

    // Present operands with start for one accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input bit push);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        first_num  = a;
        second_num = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.res = er; e.c = ec; e.o = eo; e.cyc = cyc + W;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) until all expected results have been seen.
    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   a_cyc;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_result", int'(result), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        // Basic add, unsigned wrap, signed overflow cases.
        issue(14'h0005, 14'h0003, 14'h0008, 1'b0, 1'b0, 1'b1); drain();
        issue(14'h3FFF, 14'h0001, 14'h0000, 1'b1, 1'b0, 1'b1); drain();
        issue(14'h1FFF, 14'h0001, 14'h2000, 1'b0, 1'b1, 1'b1); drain();
        issue(14'h2000, 14'h2000, 14'h0000, 1'b1, 1'b1, 1'b1); drain();

        // start during RUN is ignored.
        issue(14'h0010, 14'h0020, 14'h0030, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; first_num = 14'h1111; second_num = 14'h1111;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset mid-RUN: outputs clear immediately, no done pulse.
        issue(14'h0123, 14'h0456, 14'h0000, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_result", int'(result), 0);
        chk("midrst_carry", int'(carry), 0);
        chk("midrst_overflow", int'(overflow), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(14'h0001, 14'h0001, 14'h0002, 1'b0, 1'b0, 1'b1); drain();

        // Back-to-back with start held high through DONE.
        @(negedge clk);
        start = 1'b1; first_num = 14'h0100; second_num = 14'h0200;
        @(posedge clk);
        #1;
        a_cyc = cyc;
        e.res = 14'h0300; e.c = 1'b0; e.o = 1'b0; e.cyc = a_cyc + W;
        q.push_back(e);
        e.res = 14'h0010; e.c = 1'b0; e.o = 1'b0; e.cyc = a_cyc + 2 * W + 1;
        q.push_back(e);
        first_num = 14'h0007; second_num = 14'h0009;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/serial_add.md
SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 Parameter: WIDTH, default 14, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock; the block uses one clock only.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new addition; sampled on rising clk.
REQ-005 Port: first_num  input  WIDTH  augend, unsigned or two's complement.
REQ-006 Port: second_num  input  WIDTH  addend, unsigned or two's complement.
REQ-007 Port: result  output  WIDTH  sum of the last completed operation.
REQ-008 Port: carry  output  1  unsigned carry-out of the last completed operation.
REQ-009 Port: overflow  output  1  signed overflow of the last completed operation.
REQ-010 Port: busy  output  1  high while an addition is in progress.
REQ-011 Port: done  output  1  one-cycle pulse marking the cycle where result, carry and overflow update.

Function
REQ-012 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL latch first_num and second_num into internal shift registers, clear the internal carry and bit counter, and enter RUN.
REQ-014 In RUN, each clock edge SHALL process exactly one bit, LSB first: sum bit = a^b^c, c' = (a&b)|(a&c)|(b&c).
REQ-015 The sum bit SHALL shift into an internal accumulator at the MSB end.
REQ-016 After the WIDTH-th RUN edge, the FSM SHALL enter DONE and load result, carry and overflow from the accumulator and final carry in the same edge.
REQ-017 Latency: done SHALL be high exactly WIDTH cycles after the edge that accepted start (14 cycles at default WIDTH).
REQ-018 done SHALL be high only in DONE, for exactly one cycle.
REQ-019 DONE SHALL return to IDLE on the next edge unless start=1, in which case it enters RUN, giving back-to-back operation.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 start SHALL be ignored while in RUN; latched operands are unaffected by input changes during RUN.
REQ-022 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-023 result, carry and overflow SHALL hold their values between done pulses, including through IDLE and subsequent RUN phases.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; the wrap-around is reported only via carry.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, and clear to 0 result, carry, overflow, busy, done, the counter, the shift registers and the internal carry.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-027 After reset deassertion, the first start accepted SHALL behave per REQ-013.

Structure
REQ-028 Package serial_add_pkg SHALL hold the WIDTH default constant, the state enum type (IDLE/RUN/DONE), and the counter width constant $clog2(WIDTH+1).
REQ-029 A single sub-module full_add_cell SHALL implement the combinational one-bit sum/carry; the FSM, counter and shift registers SHALL reside in serial_add.

Verification
REQ-030 0x0005 + 0x0003, start pulsed once -> done 14 cycles later; result=0x0008, carry=0, overflow=0; busy high for 14 cycles.
REQ-031 0x3FFF + 0x0001 -> result=0x0000, carry=1, overflow=0.
REQ-032 0x1FFF + 0x0001 -> result=0x2000, carry=0, overflow=1; then 0x2000 + 0x2000 -> result=0x0000, carry=1, overflow=1.
REQ-033 start 0x0010+0x0020, then start again at cycle 5 with 0x1111+0x1111 -> second request ignored; result=0x0030 at done.
REQ-034 rst asserted at cycle 7 of RUN -> all outputs 0 in the same cycle; no done pulse; next start 0x0001+0x0001 -> result=0x0002.
REQ-035 start held high through DONE with operand pairs 0x0100+0x0200 then 0x0007+0x0009 -> done pulses 15 cycles apart; results 0x0300 then 0x0010.
